// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. It predicts the next fetch PC combinationally from lu_pc, is
// trained by resolved branches on the update port, and raises a registered
// mispredict/redirect when a resolved outcome disagrees with the prediction
// carried down the pipe.
//
// Parameters:
//   ADDR_W   PC/target width in bits
//   ENTRIES  number of entries (power of two, >= 2)
//   CTR_W    direction counter width (>= 1)
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   lu_pc                    fetch PC to look up
//   pred_hit/pred_taken      lookup hit, and hit with counter MSB set
//   pred_target              entry target when predicted taken, else lu_pc+4
//   upd_valid                a resolved branch is presented this cycle
//   upd_pc/upd_taken         resolved branch PC and its actual outcome
//   upd_target               actual taken target
//   upd_pred_taken           prediction carried with the branch
//   upd_pred_target          predicted next-PC carried with the branch
//   inv_all                  clear every valid bit (wins over a table write)
//   mispredict/redirect_pc   registered one-cycle redirect request
//
// Handshake: there is no back-pressure. upd_valid is a single-cycle
// qualifier sampled at posedge; every presented update is accepted.
//
// Build option: define BTB_BYPASS_EN to forward a same-cycle update to a
// lookup of the same index (and to force pred_hit=0 under inv_all).
// ---------------------------------------------------------------------------
module btb_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lu_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              inv_all,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0]  CTR_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_WEAK_NT = CTR_WEAK_T - 1'b1;
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

    // Table storage
    logic              ent_valid  [ENTRIES];
    logic [TAG_W-1:0]  ent_tag    [ENTRIES];
    logic [ADDR_W-1:0] ent_target [ENTRIES];
    logic [CTR_W-1:0]  ent_ctr    [ENTRIES];

    // PC fields; the two LSBs are always zero for aligned fetch
    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    logic             unused_pc_lsbs;

    assign lu_idx         = lu_pc[IDX_W+1:2];
    assign lu_tag         = lu_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign upd_tag        = upd_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{lu_pc[1:0], upd_pc[1:0]};

    // Next contents of the entry addressed by the update
    logic              upd_hit;
    logic              upd_we;
    logic [ADDR_W-1:0] new_target;
    logic [CTR_W-1:0]  new_ctr;

    always_comb begin
        upd_hit    = ent_valid[upd_idx] && (ent_tag[upd_idx] == upd_tag);
        // A not-taken miss leaves the table alone
        upd_we     = upd_valid && (upd_hit || upd_taken);
        new_target = ent_target[upd_idx];
        new_ctr    = ent_ctr[upd_idx];
        if (upd_hit) begin
            if (upd_taken) begin
                new_target = upd_target;
                if (new_ctr != CTR_MAX) new_ctr = new_ctr + 1'b1;
            end else if (new_ctr != '0) begin
                new_ctr = new_ctr - 1'b1;
            end
        end else begin
            // Allocation (or replacement of an aliasing entry) starts weakly taken
            new_target = upd_target;
            new_ctr    = CTR_WEAK_T;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_tag[i]    <= '0;
                ent_target[i] <= '0;
                ent_ctr[i]    <= CTR_WEAK_NT;
            end
        end else if (inv_all) begin
            // Only valid bits are cleared; tags, targets and counters persist
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
            end
        end else if (upd_we) begin
            ent_valid[upd_idx]  <= 1'b1;
            ent_tag[upd_idx]    <= upd_tag;
            ent_target[upd_idx] <= new_target;
            ent_ctr[upd_idx]    <= new_ctr;
        end
    end

    // Lookup
    logic              sel_valid;
    logic [TAG_W-1:0]  sel_tag;
    logic [ADDR_W-1:0] sel_target;
    logic [CTR_W-1:0]  sel_ctr;

    always_comb begin
        sel_valid  = ent_valid[lu_idx];
        sel_tag    = ent_tag[lu_idx];
        sel_target = ent_target[lu_idx];
        sel_ctr    = ent_ctr[lu_idx];
`ifdef BTB_BYPASS_EN
        if (upd_we && (upd_idx == lu_idx)) begin
            sel_valid  = 1'b1;
            sel_tag    = upd_tag;
            sel_target = new_target;
            sel_ctr    = new_ctr;
        end
        if (inv_all) sel_valid = 1'b0;
`endif
    end

    assign pred_hit    = sel_valid && (sel_tag == lu_tag);
    assign pred_taken  = pred_hit && sel_ctr[CTR_W-1];
    assign pred_target = pred_taken ? sel_target : (lu_pc + PC_STEP);

    // Mispredict detection on the resolved branch, registered for one cycle
    logic mis_cond;

    assign mis_cond = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= mis_cond;
            if (mis_cond) begin
                redirect_pc <= upd_taken ? upd_target : (upd_pc + PC_STEP);
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

    localparam int ADDR_W   = 16;
    localparam int ENTRIES  = 16;
    localparam int CTR_W    = 2;
    localparam int IDX_W    = 4;
    localparam int PC_MASK  = (1 << ADDR_W) - 1;
    localparam int CTR_TOP  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] lu_pc = '0;
    logic              pred_hit, pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic [ADDR_W-1:0] upd_target = '0;
    logic              upd_pred_taken = 1'b0;
    logic [ADDR_W-1:0] upd_pred_target = '0;
    logic              inv_all = 1'b0;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    btb_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst),
        .lu_pc(lu_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .inv_all(inv_all),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    typedef struct {
        bit v;
        int tag;
        int tgt;
        int ctr;
    } ent_t;

    ent_t m_tab [ENTRIES];
    logic [ADDR_W:0] exp_q[$];   // {mispredict, redirect_pc} expected after each edge

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input int pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int tag_of(input int pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic ent_t after_update(input ent_t e, input int upc, input bit ut, input int utgt);
        ent_t r = e;
        if (e.v && e.tag == tag_of(upc)) begin
            if (ut) begin
                r.ctr = (e.ctr < CTR_TOP) ? e.ctr + 1 : CTR_TOP;
                r.tgt = utgt;
            end else begin
                r.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
            end
        end else if (ut) begin
            r.v   = 1'b1;
            r.tag = tag_of(upc);
            r.tgt = utgt;
            r.ctr = CTR_HALF;
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_tab[i].v   = 1'b0;
            m_tab[i].tag = 0;
            m_tab[i].tgt = 0;
            m_tab[i].ctr = CTR_HALF - 1;
        end
        exp_q.delete();
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a posedge; drives one cycle, checks the lookup
    // mid-cycle and the registered mispredict just after the next edge.
    task automatic drive_cycle(input string name, input int lu, input bit uv, input int upc,
                               input bit ut, input int utgt, input bit upt, input int uptgt,
                               input bit inv);
        ent_t e;
        bit   exp_hit, exp_taken, mis;
        int   exp_tgt, redir;
        logic [ADDR_W:0] sb;

        lu_pc           = ADDR_W'(lu);
        upd_valid       = uv;
        upd_pc          = ADDR_W'(upc);
        upd_taken       = ut;
        upd_target      = ADDR_W'(utgt);
        upd_pred_taken  = upt;
        upd_pred_target = ADDR_W'(uptgt);
        inv_all         = inv;

        e = m_tab[idx_of(lu)];
`ifdef BTB_BYPASS_EN
        if (uv && idx_of(upc) == idx_of(lu)) e = after_update(e, upc, ut, utgt);
        if (inv) e.v = 1'b0;
`endif
        exp_hit   = e.v && (e.tag == tag_of(lu));
        exp_taken = exp_hit && (e.ctr >= CTR_HALF);
        exp_tgt   = exp_taken ? e.tgt : ((lu + 4) & PC_MASK);

        @(negedge clk);
        check({name, ".hit"},    32'(pred_hit),    32'(exp_hit));
        check({name, ".taken"},  32'(pred_taken),  32'(exp_taken));
        check({name, ".target"}, 32'(pred_target), 32'(exp_tgt));

        mis   = uv && ((upt != ut) || (ut && uptgt != utgt));
        redir = ut ? utgt : ((upc + 4) & PC_MASK);
        exp_q.push_back({mis, ADDR_W'(redir)});
        if (inv) begin
            for (int i = 0; i < ENTRIES; i++) m_tab[i].v = 1'b0;
        end else if (uv) begin
            m_tab[idx_of(upc)] = after_update(m_tab[idx_of(upc)], upc, ut, utgt);
        end

        @(posedge clk);
        #1;
        sb = exp_q.pop_front();
        check({name, ".mispredict"}, 32'(mispredict), 32'(sb[ADDR_W]));
        if (sb[ADDR_W]) check({name, ".redirect"}, 32'(redirect_pc), 32'(sb[ADDR_W-1:0]));
    endtask

    task automatic lookup(input string name, input int lu);
        drive_cycle(name, lu, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic update(input string name, input int lu, input int upc, input bit ut,
                          input int utgt, input bit upt, input int uptgt);
        drive_cycle(name, lu, 1'b1, upc, ut, utgt, upt, uptgt, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        upd_valid = 1'b0;
        apply_reset();
        check("rst.mispredict", 32'(mispredict), 32'd0);
        check("rst.redirect", 32'(redirect_pc), 32'd0);
        lookup("rst_lu", 'h0040);

        // allocate, then look it up
        update("alloc", 'h0040, 'h0040, 1'b1, 'h0100, 1'b0, 'h0044);
        lookup("alloc_lu", 'h0040);
        check("alloc_lu.target_const", 32'(pred_target), 32'h0100);

        // saturate downwards
        for (int i = 0; i < 3; i++) begin
            update("nt", 'h0040, 'h0040, 1'b0, 0, 1'b1, 'h0100);
            lookup("nt_lu", 'h0040);
        end

        // aliasing replacement
        update("alias", 'h0040, 'h0440, 1'b1, 'h0200, 1'b0, 'h0444);
        lookup("alias_old", 'h0040);
        lookup("alias_new", 'h0440);

        // correct prediction produces no redirect
        update("correct", 'h0440, 'h0440, 1'b1, 'h0200, 1'b1, 'h0200);
        update("correct2", 'h0100, 'h0100, 1'b1, 'h0100, 1'b1, 'h0100);

        // inv_all wins over a simultaneous update
        drive_cycle("inv", 'h0440, 1'b1, 'h00C0, 1'b1, 'h0300, 1'b0, 'h00C4, 1'b1);
        lookup("inv_a", 'h0440);
        lookup("inv_b", 'h00C0);
        lookup("inv_c", 'h0100);

        // same-cycle lookup + allocate
        update("same", 'h0080, 'h0080, 1'b1, 'h0500, 1'b0, 'h0084);
        lookup("same_next", 'h0080);

        // wrap-around of PC+4
        update("wrap", 'hFFFC, 'hFFFC, 1'b0, 0, 1'b1, 'h1234);
        lookup("wrap_lu", 'hFFFC);
        check("wrap.redirect_const", 32'(redirect_pc), 32'h0000);

        // reset mid-operation drops a pending mispredict
        update("pre_rst", 'h0080, 'h0080, 1'b1, 'h0600, 1'b0, 'h0084);
        lu_pc     = 16'h0080;
        upd_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("midrst.mispredict", 32'(mispredict), 32'd0);
        check("midrst.redirect", 32'(redirect_pc), 32'd0);
        check("midrst.hit", 32'(pred_hit), 32'd0);
        apply_reset();
        lookup("post_rst", 'h0080);

        // randomized traffic over a small PC pool to force hits and aliases
        for (int n = 0; n < 400; n++) begin
            int lu, upc, utgt, uptgt;
            bit uv, ut, upt, inv;
            lu    = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
            upc   = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 15) == 0) upc = 'hFFFC;
            uv    = ($urandom_range(0, 3) != 0);
            ut    = $urandom_range(0, 1);
            utgt  = $urandom_range(0, 3) << 8;
            upt   = $urandom_range(0, 1);
            uptgt = ($urandom_range(0, 1) != 0) ? utgt : ($urandom_range(0, 3) << 8);
            inv   = ($urandom_range(0, 39) == 0);
            drive_cycle("rand", lu, uv, upc, ut, utgt, upt, uptgt, inv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
